// File: rtl/tube_pkg.sv
// Shared definitions for the tube scanner: segment table, shifter states,
// and the sel-field width helper.
package tube_pkg;

  // Hex digit to segments, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } shift_state_e;

  // The sel field is padded up to a whole number of 8-bit 595 stages.
  function automatic int sel_w(input int digits);
    return 8 * ((digits + 7) / 8);
  endfunction

endpackage

// File: rtl/tube_scan_595_hc595_shifter.sv
// Serialises one frame MSB-first into a 74HC595 chain, then pulses the
// storage latch. sh_cp rises mid-bit so ds is stable around the edge.
//
// Handshake: start is a request that is accepted only while busy=0 (IDLE);
// frame is sampled in that same cycle. busy stays high from the following
// cycle until the latch phase ends, and done pulses for exactly one cycle
// right after st_cp falls.
module hc595_shifter
  import tube_pkg::*;
#(
  parameter int FRAME_W  = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sh_cp,
  output logic               st_cp,
  output logic               ds
);

  localparam int IDX_W = $clog2(FRAME_W);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  shift_state_e       state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [IDX_W-1:0]   idx_q;
  logic [FRAME_W-1:0] frame_q;
  logic               ds_hold_q;
  logic               done_q;
  logic               div_last;
  logic               shifting;

  assign div_last = (div_q == DIV_W'(SCLK_DIV - 1));
  assign shifting = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

  // State register plus the phase divider, bit index, frame copy and ds hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      ds_hold_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || div_last) div_q <= '0;
      else                              div_q <= div_q + 1'b1;
      if (state_q == IDLE && start) begin
        frame_q <= frame;
        idx_q   <= IDX_W'(FRAME_W - 1);
      end
      if (state_q == SHIFT_HI && div_last && idx_q != '0) idx_q <= idx_q - 1'b1;
      if (shifting) ds_hold_q <= frame_q[idx_q];
      done_q <= (state_q == LATCH) && div_last;
    end
  end

  // Next-state logic: each non-idle phase lasts SCLK_DIV clocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = SHIFT_LO;
      SHIFT_LO: if (div_last) state_d = SHIFT_HI;
      SHIFT_HI: if (div_last) state_d = (idx_q == '0) ? LATCH : SHIFT_LO;
      LATCH:    if (div_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; ds keeps its last shifted value when idle.
  always_comb begin
    sh_cp = (state_q == SHIFT_HI);
    st_cp = (state_q == LATCH);
    busy  = (state_q != IDLE);
    ds    = shifting ? frame_q[idx_q] : ds_hold_q;
    done  = done_q;
  end

endmodule

// File: rtl/tube_scan_595.sv
// Multiplexed hex-tube scanner driving a daisy chain of 74HC595s.
// Holds a snapshot of the display contents, steps the active digit at a
// fixed rate and hands one {dp, seg, sel} frame per digit to the shifter.
module tube_scan_595
  import tube_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCLK_DIV       = 2,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  localparam int SEL_W   = sel_w(DIGITS),
  localparam int FRAME_W = 8 + SEL_W,
  localparam int CD_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     disp_dp,
  input  logic [DIGITS-1:0]     disp_blank,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic                  en,
  output logic                  sh_cp,
  output logic                  st_cp,
  output logic                  ds,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CD_W-1:0]       cur_digit
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic                lz_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CD_W-1:0]     cur_digit_q;
  logic                pending_q;

  logic               tick;
  logic               start;
  logic               sh_busy;
  logic [FRAME_W-1:0] frame;
  logic [3:0]         nib;
  logic               dp_bit;
  logic               blank_bit;
  logic               upper_zero;
  logic               lz_sup;
  logic               dark;
  logic [6:0]         seg;
  logic               dp_on;
  logic [SEL_W-1:0]   sel_raw;

  assign tick  = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign start = pending_q && !sh_busy;

  // Snapshot of the display contents; blank all until the first load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '1;
      lz_q    <= 1'b0;
    end else if (load) begin
      data_q  <= disp_data;
      dp_q    <= disp_dp;
      blank_q <= disp_blank;
      lz_q    <= lz_en;
    end
  end

  // Scan timebase, active digit and the one-deep frame request flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      cur_digit_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        cur_digit_q <= (cur_digit_q == CD_W'(DIGITS - 1)) ? '0 : cur_digit_q + 1'b1;
      end
      if (start)     pending_q <= 1'b0;
      else if (tick) pending_q <= 1'b1;
    end
  end

  // Frame build for the active digit: decode, blanking, zero suppression, polarity.
  always_comb begin
    nib        = '0;
    dp_bit     = 1'b0;
    blank_bit  = 1'b0;
    upper_zero = 1'b1;
    sel_raw    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (CD_W'(i) == cur_digit_q) begin
        nib        = data_q[4*i +: 4];
        dp_bit     = dp_q[i];
        blank_bit  = blank_q[i];
        sel_raw[i] = 1'b1;
      end
      if (i >= int'(cur_digit_q) && data_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    lz_sup = lz_q && (cur_digit_q != '0) && upper_zero;
    dark   = blank_bit || lz_sup;
    seg    = dark ? 7'h00 : HEX7[nib];
    dp_on  = dark ? 1'b0 : dp_bit;
    frame  = {dp_on ^ SEG_ACTIVE_LOW, seg ^ {7{SEG_ACTIVE_LOW}},
              sel_raw ^ {SEL_W{SEL_ACTIVE_LOW}}};
  end

  hc595_shifter #(
    .FRAME_W  (FRAME_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .frame (frame),
    .start (start),
    .busy  (sh_busy),
    .done  (frame_done),
    .sh_cp (sh_cp),
    .st_cp (st_cp),
    .ds    (ds)
  );

  assign busy      = sh_busy;
  assign cur_digit = cur_digit_q;

endmodule

// File: tb/tb_tube_scan_595.sv
// Bench for tube_scan_595: an 8-digit and a 12-digit instance, frames
// decoded from the 595 pins and compared with a reference model.
module tb_tube_scan_595;

  localparam int SCLK   = 2;
  localparam int A_SCAN = 100;
  localparam int B_SCAN = 120;
  localparam int A_FW   = 16;
  localparam int B_FW   = 24;
  localparam int A_LAT  = 2 * SCLK * A_FW + SCLK + 2;
  localparam int B_LAT  = 2 * SCLK * B_FW + SCLK + 2;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    int          st_cyc;
    int          cyc;
    int          digit;
  } rx_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    bit          lz;
    int          digit;
    logic [15:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] a_data;  logic [7:0]  a_dp, a_blank;  logic a_lz, a_load, a_en;
  logic a_sh, a_st, a_ds, a_busy, a_done;  logic [2:0] a_cur;
  logic [47:0] b_data;  logic [11:0] b_dp, b_blank;  logic b_lz, b_load, b_en;
  logic b_sh, b_st, b_ds, b_busy, b_done;  logic [3:0] b_cur;

  tube_scan_595 #(.DIGITS(8), .SCLK_DIV(SCLK), .SCAN_DIV(A_SCAN),
                  .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .disp_data(a_data), .disp_dp(a_dp), .disp_blank(a_blank),
    .lz_en(a_lz), .load(a_load), .en(a_en), .sh_cp(a_sh), .st_cp(a_st), .ds(a_ds),
    .busy(a_busy), .frame_done(a_done), .cur_digit(a_cur));

  tube_scan_595 #(.DIGITS(12), .SCLK_DIV(SCLK), .SCAN_DIV(B_SCAN),
                  .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .disp_data(b_data), .disp_dp(b_dp), .disp_blank(b_blank),
    .lz_en(b_lz), .load(b_load), .en(b_en), .sh_cp(b_sh), .st_cp(b_st), .ds(b_ds),
    .busy(b_busy), .frame_done(b_done), .cur_digit(b_cur));

  initial begin
    if (A_SCAN <= A_LAT || B_SCAN <= B_LAT) begin
      $display("FAIL param_check: SCAN_DIV too small for frame length");
      $fatal(1);
    end
  end

  // ---------------- pin-level frame monitors ----------------
  rx_t rx_a[$];
  rx_t rx_b[$];
  logic [31:0] a_cap, b_cap;
  int a_nbits, a_stc, a_first_rise, a_done_total;
  int b_nbits, b_stc;
  logic a_sh_prev, b_sh_prev;

  initial begin
    a_done_total = 0;
    a_first_rise = -1;
  end

  always @(negedge clk) begin
    if (a_done) a_done_total++;
    if (rst) begin
      a_cap = '0; a_nbits = 0; a_stc = 0; a_sh_prev = 1'b0; a_first_rise = -1;
      rx_a.delete();
    end else begin
      if (a_sh && !a_sh_prev) begin
        a_cap = {a_cap[30:0], a_ds};
        a_nbits++;
        if (a_first_rise < 0) a_first_rise = cyc;
      end
      a_sh_prev = a_sh;
      if (a_st) a_stc++;
      if (a_done) begin
        rx_a.push_back('{a_cap, a_nbits, a_stc, cyc, int'(a_cur)});
        a_cap = '0; a_nbits = 0; a_stc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_cap = '0; b_nbits = 0; b_stc = 0; b_sh_prev = 1'b0;
      rx_b.delete();
    end else begin
      if (b_sh && !b_sh_prev) begin
        b_cap = {b_cap[30:0], b_ds};
        b_nbits++;
      end
      b_sh_prev = b_sh;
      if (b_st) b_stc++;
      if (b_done) begin
        rx_b.push_back('{b_cap, b_nbits, b_stc, cyc, int'(b_cur)});
        b_cap = '0; b_nbits = 0; b_stc = 0;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int t_rel = 0;

  logic [63:0] ma_data, mb_data;
  logic [15:0] ma_dp, ma_blank, mb_dp, mb_blank;
  bit          ma_lz, mb_lz;
  int          ma_dig, mb_dig, ma_last, mb_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected shifted frame, built directly from the display rules.
  function automatic logic [31:0] model_frame(input int digits, input int d,
      input logic [63:0] data, input logic [15:0] dp, input logic [15:0] blank, input bit lz);
    int          sw;
    logic [63:0] upper;
    logic [3:0]  nib;
    bit          dark;
    logic [7:0]  top8;
    logic [31:0] f;
    sw    = 8 * ((digits + 7) / 8);
    upper = data >> (4 * d);
    nib   = upper[3:0];
    dark  = blank[d] || (lz && d > 0 && upper == 64'd0);
    top8  = dark ? 8'h00 : {dp[d], SEG_REF[nib]};
    f     = (32'(top8) << sw) | (32'h1 << d);
    f     = f ^ ((32'h1 << (8 + sw)) - 32'h1);
    return f;
  endfunction

  task automatic model_reset();
    ma_data = '0; ma_dp = '0; ma_blank = 16'hFFFF; ma_lz = 1'b0; ma_dig = 0; ma_last = -1;
    mb_data = '0; mb_dp = '0; mb_blank = 16'hFFFF; mb_lz = 1'b0; mb_dig = 0; mb_last = -1;
  endtask

  task automatic check_a(input rx_t r);
    ma_dig = (ma_dig + 1) % 8;
    check("a_digit", 64'(r.digit), 64'(ma_dig));
    check("a_frame", r.frame, model_frame(8, ma_dig, ma_data, ma_dp, ma_blank, ma_lz));
    check("a_sh_cp_rises", 64'(r.nbits), 64'(A_FW));
    check("a_st_cp_cycles", 64'(r.st_cyc), 64'(SCLK));
    if (ma_last >= 0) check("a_frame_interval", 64'(r.cyc - ma_last), 64'(A_SCAN));
    ma_last = r.cyc;
  endtask

  task automatic check_b(input rx_t r);
    mb_dig = (mb_dig + 1) % 12;
    check("b_digit", 64'(r.digit), 64'(mb_dig));
    check("b_frame", r.frame, model_frame(12, mb_dig, mb_data, mb_dp, mb_blank, mb_lz));
    check("b_sh_cp_rises", 64'(r.nbits), 64'(B_FW));
    check("b_sel_padding", 64'(r.frame[15:12]), 64'h0F);
    if (mb_last >= 0) check("b_frame_interval", 64'(r.cyc - mb_last), 64'(B_SCAN));
    mb_last = r.cyc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_load = 1'b0; b_load = 1'b0; a_en = 1'b1; b_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    t_rel = cyc;
    model_reset();
  endtask

  task automatic load_a(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input bit lz);
    a_data = d; a_dp = p; a_blank = b; a_lz = lz; a_load = 1'b1;
    step();
    a_load = 1'b0;
    ma_data = 64'(d); ma_dp = 16'(p); ma_blank = 16'(b); ma_lz = lz;
    // Inputs wander afterwards; only the snapshot may matter.
    a_data = $urandom; a_dp = 8'($urandom); a_blank = 8'($urandom); a_lz = 1'($urandom_range(0, 1));
  endtask

  task automatic load_b(input logic [47:0] d, input logic [11:0] p, input logic [11:0] b, input bit lz);
    b_data = d; b_dp = p; b_blank = b; b_lz = lz; b_load = 1'b1;
    step();
    b_load = 1'b0;
    mb_data = 64'(d); mb_dp = 16'(p); mb_blank = 16'(b); mb_lz = lz;
    b_data = {16'($urandom), 32'($urandom)}; b_dp = 12'($urandom); b_blank = 12'($urandom);
  endtask

  task automatic wait_frame_a(output rx_t r, output bit ok);
    ok = 1'b0;
    r  = '{32'h0, 0, 0, 0, 0};
    for (int i = 0; i < 3 * A_SCAN && !ok; i++) begin
      if (rx_a.size() > 0) begin r = rx_a.pop_front(); ok = 1'b1; end
      else step();
    end
    if (!ok) fail_now("a_wait_frame");
  endtask

  task automatic wait_frame_b(output rx_t r, output bit ok);
    ok = 1'b0;
    r  = '{32'h0, 0, 0, 0, 0};
    for (int i = 0; i < 3 * B_SCAN && !ok; i++) begin
      if (rx_b.size() > 0) begin r = rx_b.pop_front(); ok = 1'b1; end
      else step();
    end
    if (!ok) fail_now("b_wait_frame");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  vec_t tbl [9];

  initial begin
    rx_t  r;
    bit   ok;
    bit   found;
    int   saved;
    int   held;
    int   prev_b;
    int   wraps;
    logic [31:0] rd;

    tbl[0] = '{32'h12345678, 8'h00, 8'h00, 1'b0, 1, 16'hF8FD};
    tbl[1] = '{32'h12345678, 8'h00, 8'h00, 1'b0, 0, 16'h80FE};
    tbl[2] = '{32'h12345678, 8'h00, 8'h00, 1'b0, 7, 16'hF97F};
    tbl[3] = '{32'h00000450, 8'h00, 8'h00, 1'b1, 7, 16'hFF7F};
    tbl[4] = '{32'h00000450, 8'h00, 8'h00, 1'b1, 0, 16'hC0FE};
    tbl[5] = '{32'h00000450, 8'h00, 8'h00, 1'b1, 2, 16'h99FB};
    tbl[6] = '{32'h00000450, 8'h04, 8'h08, 1'b1, 2, 16'h19FB};
    tbl[7] = '{32'h00000450, 8'h04, 8'h08, 1'b0, 3, 16'hFFF7};
    tbl[8] = '{32'h00000450, 8'h00, 8'h00, 1'b0, 7, 16'hC07F};

    a_data = '0; a_dp = '0; a_blank = '0; a_lz = 1'b0; a_load = 1'b0; a_en = 1'b1;
    b_data = '0; b_dp = '0; b_blank = '0; b_lz = 1'b0; b_load = 1'b0; b_en = 1'b1;

    // Reset values, then idle clocks with nothing loaded.
    do_reset();
    check("rst_sh_cp", 64'(a_sh), 64'd0);
    check("rst_st_cp", 64'(a_st), 64'd0);
    check("rst_ds", 64'(a_ds), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_frame_done", 64'(a_done), 64'd0);
    check("rst_cur_digit", 64'(a_cur), 64'd0);
    repeat (20) step();
    check("idle_busy", 64'(a_busy), 64'd0);
    check("idle_sh_cp", 64'(a_sh), 64'd0);

    // First frame: blank snapshot, digit 1, fixed latency.
    wait_frame_a(r, ok);
    if (ok) begin
      check_a(r);
      check("a_first_frame_blank", r.frame, 32'hFFFD);
      check("a_first_done_time", 64'(r.cyc - t_rel), 64'(A_SCAN - 1 + A_LAT));
      check("a_first_rise_time", 64'(a_first_rise - t_rel), 64'(A_SCAN - 1 + 2 + SCLK));
    end

    // Table of hand-derived frames.
    for (int v = 0; v < 9; v++) begin
      load_a(tbl[v].data, tbl[v].dp, tbl[v].blank, tbl[v].lz);
      found = 1'b0;
      for (int k = 0; k < 9 && !found; k++) begin
        wait_frame_a(r, ok);
        if (!ok) break;
        check_a(r);
        if (ma_dig == tbl[v].digit) begin
          check($sformatf("tbl%0d_frame", v), r.frame, 32'(tbl[v].exp));
          found = 1'b1;
        end
      end
      if (!found) fail_now($sformatf("tbl%0d_digit_not_seen", v));
    end

    // Randomised snapshots against the model.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        rd = 32'($urandom) >> $urandom_range(0, 31);
        load_a(rd, 8'($urandom), 8'($urandom) & 8'($urandom) & 8'($urandom),
               1'($urandom_range(0, 1)));
      end
      wait_frame_a(r, ok);
      if (ok) check_a(r);
    end

    // en=0 mid-frame: the frame finishes, then the scan freezes.
    ok = 1'b0;
    for (int i = 0; i < 2 * A_SCAN && !ok; i++) begin
      if (a_busy) ok = 1'b1; else step();
    end
    if (!ok) fail_now("a_wait_busy");
    a_en = 1'b0;
    wait_frame_a(r, ok);
    if (ok) check_a(r);
    held = int'(a_cur);
    repeat (5 * A_SCAN) step();
    check("a_pause_no_frames", 64'(rx_a.size()), 64'd0);
    check("a_pause_busy", 64'(a_busy), 64'd0);
    check("a_pause_digit_held", 64'(a_cur), 64'(held));
    a_en = 1'b1;
    ma_last = -1;
    wait_frame_a(r, ok);
    if (ok) check_a(r);

    // Reset in the middle of shifting.
    ok = 1'b0;
    for (int i = 0; i < 2 * A_SCAN && !ok; i++) begin
      if (a_nbits == 10) ok = 1'b1; else step();
    end
    if (!ok) fail_now("a_wait_bit10");
    saved = a_done_total;
    rst = 1'b1;
    step();
    check("midrst_sh_cp", 64'(a_sh), 64'd0);
    check("midrst_st_cp", 64'(a_st), 64'd0);
    check("midrst_ds", 64'(a_ds), 64'd0);
    check("midrst_busy", 64'(a_busy), 64'd0);
    check("midrst_frame_done", 64'(a_done), 64'd0);
    step();
    step();
    rst = 1'b0;
    t_rel = cyc;
    model_reset();
    repeat (40) step();
    check("midrst_no_done_pulse", 64'(a_done_total), 64'(saved));
    wait_frame_a(r, ok);
    if (ok) begin
      check_a(r);
      check("a_after_rst_done_time", 64'(r.cyc - t_rel), 64'(A_SCAN - 1 + A_LAT));
    end

    // 12-digit instance: 24-bit frames, padded sel, wrap 11 -> 0.
    wait_frame_b(r, ok);
    if (ok) begin
      check_b(r);
      check("b_first_done_time", 64'(r.cyc - t_rel), 64'(B_SCAN - 1 + B_LAT));
    end
    load_b(48'h000009A0_B000, 12'h010, 12'h000, 1'b1);
    prev_b = mb_dig;
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 2 && $urandom_range(0, 2) == 0) begin
        load_b({16'($urandom), 32'($urandom)} >> $urandom_range(0, 47),
               12'($urandom), 12'($urandom) & 12'($urandom), 1'($urandom_range(0, 1)));
      end
      wait_frame_b(r, ok);
      if (!ok) break;
      check_b(r);
      if (prev_b == 11 && r.digit == 0) wraps++;
      prev_b = r.digit;
    end
    check("b_wrap_11_to_0", 64'(wraps > 0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
